// File: rtl/pixelbox_pkg.sv
// pixelbox_pkg: mode index defaults shared by key_ctl and mode_switch_sync
package pixelbox_pkg;
  localparam int CNT_WIDTH_DEF = 2;
  localparam int CNT_MAX_DEF   = 2;
endpackage

// File: rtl/vs_edge_det.sv
// vs_edge_det: one-cycle frame-start strobe on the inactive-to-active edge of vs_in
//   clk, rstn : clock, async active-low reset
//   vs_in     : frame sync, active level VS_POL
//   fs        : high in the first cycle vs_in is at VS_POL
module vs_edge_det #(
  parameter bit VS_POL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic vs_in,
  output logic fs
);
  logic r_vs;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) r_vs <= ~VS_POL;
    else       r_vs <= vs_in;
  assign fs = (vs_in == VS_POL) && (r_vs != VS_POL);
endmodule

// File: rtl/mode_switch_sync.sv
// mode_switch_sync: applies a requested mode only at a frame start, then blanks BLANK_FRAMES frames
//   clk, rstn   : clock, async active-low reset
//   ctrl_in     : requested mode index (values above CNT_MAX are ignored)
//   vs_in       : frame sync
//   mode_out    : mode applied to the video path
//   mode_update : one-cycle pulse when mode_out changes
//   blank       : video path must output black
//   busy        : a switch is pending or blanking
module mode_switch_sync
  import pixelbox_pkg::*;
#(
  parameter int CNT_WIDTH    = CNT_WIDTH_DEF,
  parameter int CNT_MAX      = CNT_MAX_DEF,
  parameter int BLANK_FRAMES = 2,
  parameter bit VS_POL       = 1'b1
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [CNT_WIDTH-1:0] ctrl_in,
  input  logic                 vs_in,
  output logic [CNT_WIDTH-1:0] mode_out,
  output logic                 mode_update,
  output logic                 blank,
  output logic                 busy
);
  localparam logic [1:0] IDLE = 2'd0, WAIT_FS = 2'd1, BLANK = 2'd2;
  localparam int FW = BLANK_FRAMES > 0 ? $clog2(BLANK_FRAMES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] MAX_IDX = CNT_WIDTH'(CNT_MAX);
  localparam logic [FW-1:0] LAST = FW'(BLANK_FRAMES);
  localparam bit HAS_BLANK = BLANK_FRAMES != 0;
  logic [1:0] r_state, w_state;
  logic [CNT_WIDTH-1:0] r_mode, w_mode, r_pend, w_pend, w_req;
  logic [FW-1:0] r_cnt, w_cnt;
  logic r_upd, w_upd, r_blank, w_blank, r_busy;
  logic w_fs, w_legal;
  vs_edge_det #(.VS_POL(VS_POL)) u_fs (.clk(clk), .rstn(rstn), .vs_in(vs_in), .fs(w_fs));
  assign w_legal = ctrl_in <= MAX_IDX;
  // last legal request wins; an illegal index keeps the pending one
  assign w_req = w_legal ? ctrl_in : r_pend;
  always_comb begin
    w_state = r_state;
    w_mode  = r_mode;
    w_pend  = r_pend;
    w_cnt   = r_cnt;
    w_upd   = 1'b0;
    w_blank = r_blank;
    case (r_state)
      IDLE:
        if (w_legal && ctrl_in != r_mode) begin
          w_pend  = ctrl_in;
          w_state = WAIT_FS;
        end
      WAIT_FS:
        if (w_legal && ctrl_in == r_mode) w_state = IDLE;
        else if (w_fs) begin
          w_mode  = w_req;
          w_upd   = 1'b1;
          w_cnt   = HAS_BLANK ? FW'(1) : '0;
          w_blank = HAS_BLANK;
          w_state = HAS_BLANK ? BLANK : IDLE;
        end else w_pend = w_req;
      BLANK:
        if (w_fs) begin
          w_cnt   = (r_cnt == LAST) ? '0 : r_cnt + 1'b1;
          w_blank = r_cnt != LAST;
          w_state = (r_cnt == LAST) ? IDLE : BLANK;
        end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      r_state <= IDLE;
      r_mode  <= '0;
      r_pend  <= '0;
      r_cnt   <= '0;
      r_upd   <= 1'b0;
      r_blank <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_mode  <= w_mode;
      r_pend  <= w_pend;
      r_cnt   <= w_cnt;
      r_upd   <= w_upd;
      r_blank <= w_blank;
      r_busy  <= w_state != IDLE;
    end
  assign mode_out    = r_mode;
  assign mode_update = r_upd;
  assign blank       = r_blank;
  assign busy        = r_busy;
endmodule

// File: tb/tb_mode_switch_sync.sv
// tb_mode_switch_sync: directed scoreboard bench for mode_switch_sync (default and zero-blank builds)
module tb_mode_switch_sync;
  localparam int FP = 1000;
  logic clk = 1'b0;
  logic rstn, rstn0, vs_in;
  logic [1:0] ctrl_in, ctrl0;
  logic [1:0] mode_out, mode0;
  logic mode_update, blank, busy, upd0, blank0, busy0;
  logic saw_blank0 = 1'b0;
  int n_assert = 0;
  int n_fail = 0;
  logic [1:0] q[$];
  always #5 clk = ~clk;
  mode_switch_sync dut (
    .clk(clk), .rstn(rstn), .ctrl_in(ctrl_in), .vs_in(vs_in),
    .mode_out(mode_out), .mode_update(mode_update), .blank(blank), .busy(busy)
  );
  mode_switch_sync #(.BLANK_FRAMES(0)) dut0 (
    .clk(clk), .rstn(rstn0), .ctrl_in(ctrl0), .vs_in(vs_in),
    .mode_out(mode0), .mode_update(upd0), .blank(blank0), .busy(busy0)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic fire_fs();
    vs_in = 1'b1;
    tick(1);
    vs_in = 1'b0;
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (blank0 === 1'b1) saw_blank0 = 1'b1;
    if (mode_update === 1'b1) begin
      if (q.size() == 0) chk("unexpected_update", 32'(mode_out), 32'hdead);
      else chk("sb_mode", 32'(mode_out), 32'(q.pop_front()));
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
  initial begin
    rstn = 1'b0; rstn0 = 1'b0; vs_in = 1'b0; ctrl_in = 2'd0; ctrl0 = 2'd0;
    tick(3);
    chk("rst_mode", 32'(mode_out), 0);
    chk("rst_upd", 32'(mode_update), 0);
    chk("rst_blank", 32'(blank), 0);
    chk("rst_busy", 32'(busy), 0);
    rstn = 1'b1;
    tick(2);
    ctrl_in = 2'd1;
    tick(1);
    chk("req_busy", 32'(busy), 1);
    chk("req_noblank", 32'(blank), 0);
    tick(FP);
    q.push_back(2'd1);
    fire_fs();
    chk("sw1_mode", 32'(mode_out), 1);
    chk("sw1_upd", 32'(mode_update), 1);
    chk("sw1_blank", 32'(blank), 1);
    tick(1);
    chk("sw1_upd_drop", 32'(mode_update), 0);
    tick(FP);
    fire_fs();
    chk("sw1_f2_blank", 32'(blank), 1);
    chk("sw1_f2_busy", 32'(busy), 1);
    tick(FP);
    fire_fs();
    chk("sw1_f3_blank", 32'(blank), 0);
    chk("sw1_f3_busy", 32'(busy), 0);
    ctrl_in = 2'd0;
    vs_in = 1'b1;
    tick(1);
    vs_in = 1'b0;
    @(negedge clk);
    chk("samefs_busy", 32'(busy), 1);
    chk("samefs_mode", 32'(mode_out), 1);
    tick(FP / 2);
    ctrl_in = 2'd2;
    tick(FP / 2);
    q.push_back(2'd2);
    fire_fs();
    chk("last_wins_mode", 32'(mode_out), 2);
    chk("last_wins_blank", 32'(blank), 1);
    ctrl_in = 2'd1;
    tick(FP);
    fire_fs();
    chk("blank_hold_mode", 32'(mode_out), 2);
    chk("blank_hold_busy", 32'(busy), 1);
    tick(FP);
    fire_fs();
    chk("blank_end", 32'(blank), 0);
    chk("blank_end_busy", 32'(busy), 0);
    tick(1);
    chk("reeval_busy", 32'(busy), 1);
    tick(FP);
    q.push_back(2'd1);
    fire_fs();
    chk("sw3_mode", 32'(mode_out), 1);
    tick(FP);
    fire_fs();
    tick(FP);
    fire_fs();
    chk("sw3_done", 32'(busy), 0);
    ctrl_in = 2'd2;
    tick(1);
    chk("cancel_busy1", 32'(busy), 1);
    ctrl_in = 2'd1;
    tick(1);
    chk("cancel_busy0", 32'(busy), 0);
    tick(FP);
    fire_fs();
    chk("cancel_mode", 32'(mode_out), 1);
    chk("cancel_blank", 32'(blank), 0);
    ctrl_in = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk("illegal_busy", 32'(busy), 0);
      tick(FP);
      fire_fs();
      chk("illegal_mode", 32'(mode_out), 1);
      chk("illegal_busy_fs", 32'(busy), 0);
    end
    ctrl_in = 2'd2;
    tick(FP);
    q.push_back(2'd2);
    fire_fs();
    chk("prerst_blank", 32'(blank), 1);
    tick(10);
    rstn = 1'b0;
    #1;
    chk("arst_mode", 32'(mode_out), 0);
    chk("arst_upd", 32'(mode_update), 0);
    chk("arst_blank", 32'(blank), 0);
    chk("arst_busy", 32'(busy), 0);
    ctrl_in = 2'd0;
    tick(3);
    rstn = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick(FP);
      fire_fs();
      chk("postrst_mode", 32'(mode_out), 0);
      chk("postrst_busy", 32'(busy), 0);
    end
    ctrl_in = 2'd2;
    tick(FP);
    q.push_back(2'd2);
    fire_fs();
    chk("postrst_sw", 32'(mode_out), 2);
    rstn0 = 1'b1;
    tick(2);
    ctrl0 = 2'd2;
    tick(1);
    chk("b0_busy", 32'(busy0), 1);
    tick(FP);
    fire_fs();
    chk("b0_mode", 32'(mode0), 2);
    chk("b0_upd", 32'(upd0), 1);
    chk("b0_blank", 32'(blank0), 0);
    chk("b0_idle", 32'(busy0), 0);
    tick(1);
    chk("b0_upd_drop", 32'(upd0), 0);
    tick(FP);
    fire_fs();
    chk("b0_mode_hold", 32'(mode0), 2);
    chk("b0_never_blank", 32'(saw_blank0), 0);
    chk("sb_empty", 32'(q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
